// File: rtl/pixel_byte_serializer.sv
// Pixel-to-byte serializer: accepts 24-bit RGB pixels and emits them as
// R, G, B bytes. It tracks the row/col position of each pixel within a
// frame, flags the final byte of a frame, and pulses frame_done after it.
module pixel_byte_serializer #(
  parameter int height = 512,
  parameter int width  = 768
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  pix_valid,
  output logic                                                  pix_ready,
  input  logic [23:0]                                           pix_data,
  output logic                                                  byte_valid,
  input  logic                                                  byte_ready,
  output logic [7:0]                                            byte_data,
  output logic                                                  byte_last,
  output logic [((height > 1) ? $clog2(height) : 1)-1:0]        row,
  output logic [((width > 1) ? $clog2(width) : 1)-1:0]          col,
  output logic                                                  frame_done
);

  localparam int RW = (height > 1) ? $clog2(height) : 1;
  localparam int CW = (width > 1) ? $clog2(width) : 1;
  localparam logic [RW-1:0] ROW_MAX = RW'(height - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(width - 1);
  localparam logic [1:0]    IDX_R   = 2'd0;
  localparam logic [1:0]    IDX_G   = 2'd1;
  localparam logic [1:0]    IDX_B   = 2'd2;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_SEND  = 1'b1
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [1:0]    idx_r, idx_nxt_s;
  logic [23:0]   pix_r, pix_nxt_s;
  logic [7:0]    byte_data_r, byte_nxt_s;
  logic          byte_last_r, byte_last_nxt_s;
  logic [RW-1:0] row_r, row_nxt_s;
  logic [CW-1:0] col_r, col_nxt_s;
  logic          frame_done_r;
  logic          pix_ready_s;
  logic          pix_xfer_s;
  logic          byte_xfer_s;
  logic          idx_is_b_s;

  assign idx_is_b_s  = (idx_r == IDX_B);
  // Gating with rst_n keeps pix_ready low for the whole reset interval.
  assign pix_ready   = rst_n & pix_ready_s;
  assign pix_xfer_s  = pix_valid & pix_ready_s;
  assign byte_xfer_s = (state_r == ST_SEND) & byte_ready;

  assign byte_valid  = (state_r == ST_SEND);
  assign byte_data   = byte_data_r;
  assign byte_last   = byte_last_r;
  assign row         = row_r;
  assign col         = col_r;
  assign frame_done  = frame_done_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: B byte leaving either reloads (no bubble) or empties.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (pix_xfer_s) state_nxt_s = ST_SEND;
        else            state_nxt_s = ST_EMPTY;
      end
      ST_SEND: begin
        if (byte_xfer_s && idx_is_b_s) state_nxt_s = pix_xfer_s ? ST_SEND : ST_EMPTY;
        else                           state_nxt_s = ST_SEND;
      end
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

  // Output logic: pix_ready is combinational on byte_ready while the B byte is up.
  always_comb begin
    pix_ready_s = 1'b0;
    case (state_r)
      ST_EMPTY: pix_ready_s = 1'b1;
      ST_SEND: begin
        if (idx_is_b_s) pix_ready_s = byte_ready;
        else            pix_ready_s = 1'b0;
      end
      default: pix_ready_s = 1'b0;
    endcase
  end

  // Datapath next values: byte index, held pixel, presented byte and position.
  always_comb begin
    idx_nxt_s  = idx_r;
    pix_nxt_s  = pix_r;
    byte_nxt_s = byte_data_r;
    row_nxt_s  = row_r;
    col_nxt_s  = col_r;

    if (byte_xfer_s && idx_is_b_s) begin
      if (col_r == COL_MAX) begin
        col_nxt_s = {CW{1'b0}};
        if (row_r == ROW_MAX) row_nxt_s = {RW{1'b0}};
        else                  row_nxt_s = row_r + RW'(1);
      end else begin
        col_nxt_s = col_r + CW'(1);
      end
    end else begin
      col_nxt_s = col_r;
    end

    if (pix_xfer_s) begin
      idx_nxt_s  = IDX_R;
      pix_nxt_s  = pix_data;
      byte_nxt_s = pix_data[23:16];
    end else if (byte_xfer_s && !idx_is_b_s) begin
      idx_nxt_s  = idx_r + 2'd1;
      byte_nxt_s = (idx_r == IDX_R) ? pix_r[15:8] : pix_r[7:0];
    end else if (byte_xfer_s) begin
      idx_nxt_s  = IDX_R;
    end else begin
      idx_nxt_s  = idx_r;
    end

    byte_last_nxt_s = (state_nxt_s == ST_SEND) && (idx_nxt_s == IDX_B) &&
                      (row_nxt_s == ROW_MAX) && (col_nxt_s == COL_MAX);
  end

  // Datapath registers; all outputs except pix_ready come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r        <= 2'd0;
      pix_r        <= 24'd0;
      byte_data_r  <= 8'd0;
      byte_last_r  <= 1'b0;
      row_r        <= {RW{1'b0}};
      col_r        <= {CW{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      idx_r        <= idx_nxt_s;
      pix_r        <= pix_nxt_s;
      byte_data_r  <= byte_nxt_s;
      byte_last_r  <= byte_last_nxt_s;
      row_r        <= row_nxt_s;
      col_r        <= col_nxt_s;
      frame_done_r <= byte_xfer_s & byte_last_r;
    end
  end

endmodule

// File: tb/tb_pixel_byte_serializer.sv
// Self-checking bench for pixel_byte_serializer (width=4, height=2):
// a scoreboard predicts each byte and its row/col/last flags when a pixel
// is accepted and checks them as bytes leave; directed steps cover latency,
// stalls, frame boundaries, reset and a randomized stream.
module tb_pixel_byte_serializer;

  localparam int W = 4;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pix_valid;
  logic        pix_ready;
  logic [23:0] pix_data;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic [0:0]  row;
  logic [1:0]  col;
  logic        frame_done;

  typedef struct packed {
    logic [7:0] b;
    logic       last;
    logic [0:0] r;
    logic [1:0] c;
  } exp_t;

  exp_t sb[$];
  int   xfer_cyc[$];
  int   fd_cyc[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   m_row = 0;
  int   m_col = 0;
  logic fd_exp = 1'b0;
  logic fd_next;
  logic rand_rdy = 1'b0;
  exp_t e;
  int   fd0;

  pixel_byte_serializer #(.height(H), .width(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
    .byte_last(byte_last), .row(row), .col(col), .frame_done(frame_done)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_pix(input logic [23:0] d, input int gap);
    int t;
    logic done;
    pix_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    pix_valid = 1'b1;
    pix_data  = d;
    t = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (pix_ready) done = 1'b1;
      else if (t > 300) begin
        chk("pixel_accept_timeout", 32'd0, 32'd1);
        pix_valid = 1'b0;
        done = 1'b1;
      end else t++;
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while ((sb.size() != 0 || byte_valid) && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    chk(tag, 32'((sb.size() == 0) && !byte_valid), 32'd1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    pix_valid  = 1'b0;
    pix_data   = 24'd0;
    byte_ready = 1'b0;

    fork
      // Monitor: predicts bytes on pixel acceptance, checks them on transfer.
      forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
          sb.delete();
          m_row  = 0;
          m_col  = 0;
          fd_exp = 1'b0;
        end else begin
          chk("frame_done", 32'(frame_done), 32'(fd_exp));
          if (frame_done) fd_cyc.push_back(cyc);
          fd_next = 1'b0;
          if (pix_valid && pix_ready) begin
            sb.push_back('{pix_data[23:16], 1'b0, 1'(m_row), 2'(m_col)});
            sb.push_back('{pix_data[15:8],  1'b0, 1'(m_row), 2'(m_col)});
            sb.push_back('{pix_data[7:0], (m_row == H-1) && (m_col == W-1), 1'(m_row), 2'(m_col)});
            if (m_col == W-1) begin
              m_col = 0;
              m_row = (m_row == H-1) ? 0 : m_row + 1;
            end else m_col++;
          end
          if (byte_valid && byte_ready) begin
            if (sb.size() == 0) chk("unexpected_byte", 32'd1, 32'd0);
            else begin
              e = sb.pop_front();
              chk("byte_data", 32'(byte_data), 32'(e.b));
              chk("byte_last", 32'(byte_last), 32'(e.last));
              chk("row", 32'(row), 32'(e.r));
              chk("col", 32'(col), 32'(e.c));
              fd_next = e.last;
            end
            xfer_cyc.push_back(cyc);
          end
          fd_exp = fd_next;
        end
      end
      // Downstream stall generator for the randomized phase.
      forever begin
        @(posedge clk); #1;
        if (rand_rdy) byte_ready = ($urandom_range(0, 3) != 0);
      end
    join_none

    // Asynchronous reset takes effect without a clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_byte_valid", 32'(byte_valid), 32'd0);
    chk("rst_pix_ready", 32'(pix_ready), 32'd0);
    chk("rst_byte_data", 32'(byte_data), 32'd0);
    chk("rst_byte_last", 32'(byte_last), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_row", 32'(row), 32'd0);
    chk("rst_col", 32'(col), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    byte_ready = 1'b1;
    @(negedge clk);
    chk("pix_ready_after_reset", 32'(pix_ready), 32'd1);
    @(posedge clk); #1;

    // Single pixel latency.
    pix_data = 24'h112233;
    pix_valid = 1'b1;
    @(posedge clk); #1;
    pix_valid = 1'b0;
    chk("t1_valid", 32'(byte_valid), 32'd1);
    chk("t1_r", 32'(byte_data), 32'h11);
    chk("t1_row", 32'(row), 32'd0);
    chk("t1_col", 32'(col), 32'd0);
    @(posedge clk); #1;
    chk("t1_g", 32'(byte_data), 32'h22);
    @(posedge clk); #1;
    chk("t1_b", 32'(byte_data), 32'h33);
    @(posedge clk); #1;
    chk("t1_idle", 32'(byte_valid), 32'd0);

    // One full frame back-to-back.
    do_reset();
    xfer_cyc.delete();
    fd0 = fd_cyc.size();
    for (int i = 0; i < 8; i++) push_pix({8'(3*i+1), 8'(3*i+2), 8'(3*i+3)}, 0);
    wait_drain("t2_drain");
    chk("t2_bytes", 32'(xfer_cyc.size()), 32'd24);
    chk("t2_no_idle", (xfer_cyc.size() == 24) ? 32'(xfer_cyc[23] - xfer_cyc[0]) : 32'hFFFF_FFFF, 32'd23);
    chk("t2_fd_count", 32'(fd_cyc.size() - fd0), 32'd1);
    chk("t2_fd_timing", (fd_cyc.size() > fd0 && xfer_cyc.size() == 24) ? 32'(fd_cyc[fd0] - xfer_cyc[23]) : 32'hFFFF_FFFF, 32'd1);
    chk("t2_row", 32'(row), 32'd0);
    chk("t2_col", 32'(col), 32'd0);

    // Downstream stall during the G byte.
    pix_data = 24'hAABBCC;
    pix_valid = 1'b1;
    @(posedge clk); #1;
    pix_valid = 1'b0;
    chk("t3_r", 32'(byte_data), 32'hAA);
    @(posedge clk); #1;
    chk("t3_g", 32'(byte_data), 32'hBB);
    byte_ready = 1'b0;
    pix_valid = 1'b1;
    pix_data = 24'hDEADBE;
    repeat (5) begin
      @(negedge clk);
      chk("t3_stall_data", 32'(byte_data), 32'hBB);
      chk("t3_stall_pix_ready", 32'(pix_ready), 32'd0);
      chk("t3_stall_valid", 32'(byte_valid), 32'd1);
      chk("t3_stall_col", 32'(col), 32'd0);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    byte_ready = 1'b1;
    @(negedge clk);
    chk("t3_resume_g", 32'(byte_data), 32'hBB);
    @(posedge clk); #1;
    chk("t3_resume_b", 32'(byte_data), 32'hCC);
    wait_drain("t3_drain");

    // Two frames streamed continuously.
    do_reset();
    xfer_cyc.delete();
    fd0 = fd_cyc.size();
    for (int i = 0; i < 16; i++) push_pix(24'($urandom), 0);
    wait_drain("t4_drain");
    chk("t4_bytes", 32'(xfer_cyc.size()), 32'd48);
    chk("t4_fd_count", 32'(fd_cyc.size() - fd0), 32'd2);
    chk("t4_fd_spacing", (fd_cyc.size() == fd0 + 2) ? 32'(fd_cyc[fd0+1] - fd_cyc[fd0]) : 32'hFFFF_FFFF, 32'd24);

    // Reset in the middle of pixel (0,1).
    do_reset();
    push_pix(24'h010203, 0);
    push_pix(24'h040506, 0);
    @(posedge clk); #1;
    chk("t5_g_shown", 32'(byte_data), 32'h05);
    chk("t5_col_before", 32'(col), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_valid_drop", 32'(byte_valid), 32'd0);
    chk("t5_col_reset", 32'(col), 32'd0);
    chk("t5_data_reset", 32'(byte_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t5_pix_ready", 32'(pix_ready), 32'd1);
    @(posedge clk); #1;
    chk("t5_no_partial", 32'(byte_valid), 32'd0);
    pix_data = 24'h0A0B0C;
    pix_valid = 1'b1;
    @(posedge clk); #1;
    pix_valid = 1'b0;
    chk("t5_new_r", 32'(byte_data), 32'h0A);
    chk("t5_new_row", 32'(row), 32'd0);
    chk("t5_new_col", 32'(col), 32'd0);
    wait_drain("t5_drain");

    // Randomized valid/ready stalls over 1000 pixels.
    do_reset();
    xfer_cyc.delete();
    fd0 = fd_cyc.size();
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) push_pix(24'($urandom), $urandom_range(0, 2));
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    byte_ready = 1'b1;
    wait_drain("t6_drain");
    chk("t6_bytes", 32'(xfer_cyc.size()), 32'd3000);
    chk("t6_fd_count", 32'(fd_cyc.size() - fd0), 32'd125);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pixel_byte_serializer.md
PIXEL_BYTE_SERIALIZER -- requirements
Module: pixel_byte_serializer

Interface
REQ-001 Parameter: height, default 512, frame height in pixel rows.
REQ-002 Parameter: width, default 768, frame width in pixels per row.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pix_valid  input  1  upstream pixel present.
REQ-006 pix_ready  output  1  serializer accepts pixel this cycle.
REQ-007 pix_data  input  24  pixel; R=[23:16], G=[15:8], B=[7:0].
REQ-008 byte_valid  output  1  byte_data holds a valid byte.
REQ-009 byte_ready  input  1  downstream accepts byte this cycle.
REQ-010 byte_data  output  8  serialized byte.
REQ-011 byte_last  output  1  high with the B byte of the final pixel of a frame.
REQ-012 row  output  clog2(height)  row index of the pixel currently being emitted.
REQ-013 col  output  clog2(width)  column index of the pixel currently being emitted.
REQ-014 frame_done  output  1  one-cycle pulse after the final byte of a frame transfers.

Function
REQ-015 Pixel handshake: transfer when pix_valid and pix_ready are both high at a rising edge.
REQ-016 Byte handshake: transfer when byte_valid and byte_ready are both high at a rising edge.
REQ-017 Serializer SHALL hold one pixel register plus a 2-bit byte index (0=R, 1=G, 2=B); states EMPTY and SEND.
REQ-018 EMPTY: byte_valid=0, pix_ready=1; a pixel transfer loads the register, sets index 0, enters SEND.
REQ-019 SEND: byte_valid=1; byte_data = R, G or B of the held pixel by index.
REQ-020 SEND, byte transfer at index 0 or 1: index increments, pix_ready=0.
REQ-021 SEND, index 2: pix_ready = byte_ready (combinational).
REQ-022 SEND, index 2, byte transfer with simultaneous pixel transfer: load the new pixel, index 0, remain in SEND, with no bubble.
REQ-023 SEND, index 2, byte transfer without a pixel transfer: go to EMPTY.
REQ-024 Latency: a pixel accepted at edge N SHALL present R from N+1; with byte_ready held high, G follows at N+2 and B at N+3.
REQ-025 Peak throughput: one byte per cycle, one pixel per 3 cycles.
REQ-026 byte_data, byte_last, row and col SHALL stay stable while byte_valid=1 and byte_ready=0.
REQ-027 col increments on each B byte transfer; wraps width-1 -> 0 and increments row.
REQ-028 row wraps height-1 -> 0 when col wraps at row height-1 (end of frame).
REQ-029 byte_last = byte_valid and index==2 and row==height-1 and col==width-1.
REQ-030 frame_done SHALL be registered: high for exactly the one cycle after the byte_last transfer edge.
REQ-031 The next frame starts immediately at row 0, col 0; pixels are accepted in the frame_done cycle.
REQ-032 pix_data is ignored when pix_valid=0; pix_valid with pix_ready=0 SHALL NOT alter state.

Reset
REQ-033 rst_n low SHALL immediately force: state EMPTY, index 0, row 0, col 0, byte_valid 0, byte_last 0, frame_done 0, pix_ready 0, byte_data 0.
REQ-034 Reset mid-pixel SHALL discard the held pixel and any unsent bytes; no partial pixel is emitted after release.
REQ-035 pix_ready SHALL be 1 in the first cycle after rst_n rises.

Verification (width=4, height=2 unless stated)
REQ-036 Single pixel 0x112233, byte_ready=1 -> bytes 0x11, 0x22, 0x33 on three consecutive cycles, starting 1 cycle after acceptance; row=0, col=0.
REQ-037 Eight back-to-back pixels, byte_ready=1 -> 24 bytes with no idle cycle; byte_last only on the 24th; frame_done pulses on the next cycle; row/col back to 0/0.
REQ-038 byte_ready low for 5 cycles during the G byte -> byte_data stays at the G byte value; pix_ready stays 0; the sequence resumes with G.
REQ-039 Two frames streamed continuously -> 48 bytes; exactly two frame_done pulses, 24 bytes apart.
REQ-040 rst_n pulsed low after the R byte of pixel (0,1) -> byte_valid drops at once; after release, the next accepted pixel is emitted at row 0, col 0.
REQ-041 Random pix_valid and byte_ready stalls, 1000 pixels -> output byte stream equals the input R,G,B order exactly; frame_done count = 1000/8.
